freq_meter: RTL and testbench

//  Gated frequency counter: counts rising edges of an asynchronous input sig_i

---
 rtl/freq_meter.sv | 145 ++++++++++++++
 tb/tb_freq_meter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_i over a
// window of GATE_CYCLES clk_i cycles and publishes the count once per window.
//
// state | meaning
// IDLE  | not measuring, outputs hold the last published result
// ARM   | one cycle clearing the window counters, stale edge discarded
// GATE  | counting edges; terminal cycle publishes and restarts the window
module freq_meter #(
   parameter int GATE_CYCLES = 25_000_000,
   parameter int GATE_W      = 25,
   parameter int CNT_W       = 24
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sig_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] freq_o,
   output logic             valid_o,
   output logic             ovf_o,
   output logic             busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      GATE = 2'd2
   } state_t;

   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   state_t state_q, state_d;

   logic s1_q, s2_q, s3_q;
   logic edge_det;

   logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
   logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d, edge_cnt_inc;
   logic              ovf_int_q, ovf_int_d, ovf_int_inc;
   logic [CNT_W-1:0]  freq_q, freq_d;
   logic              ovf_q, ovf_d;
   logic              valid_q, valid_d;
   logic              cnt_at_max;
   logic              terminal;

   // s1/s2 form the synchroniser; s3 only delays s2 for edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sig_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign edge_det = s2_q & ~s3_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = en_i ? ARM : IDLE;
         ARM:     state_d = en_i ? GATE : IDLE;
         GATE:    state_d = en_i ? GATE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = (state_q == ARM) || (state_q == GATE);
   end

   // Saturating count including the current cycle's edge
   assign cnt_at_max   = (edge_cnt_q == CNT_MAX);
   assign edge_cnt_inc = (edge_det && !cnt_at_max) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
   assign ovf_int_inc  = ovf_int_q | (edge_det & cnt_at_max);
   assign terminal     = (gate_cnt_q == GATE_LAST);

   always_comb begin
      gate_cnt_d = gate_cnt_q;
      edge_cnt_d = edge_cnt_q;
      ovf_int_d  = ovf_int_q;
      freq_d     = freq_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;
      case (state_q)
         ARM: begin
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            ovf_int_d  = 1'b0;
         end
         GATE: begin
            if (en_i) begin
               if (terminal) begin
                  // Publish and restart with no dead cycle between windows
                  freq_d     = edge_cnt_inc;
                  ovf_d      = ovf_int_inc;
                  valid_d    = 1'b1;
                  gate_cnt_d = '0;
                  edge_cnt_d = '0;
                  ovf_int_d  = 1'b0;
               end else begin
                  gate_cnt_d = gate_cnt_q + GATE_W'(1);
                  edge_cnt_d = edge_cnt_inc;
                  ovf_int_d  = ovf_int_inc;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         ovf_int_q  <= 1'b0;
         freq_q     <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         ovf_int_q  <= ovf_int_d;
         freq_q     <= freq_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign freq_o  = freq_q;
   assign ovf_o   = ovf_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed stimulus pushes expected window results into
// a queue; a monitor pops and compares on every valid_o pulse.
module tb_freq_meter;

   localparam int GC = 100;
   localparam int GW = 7;
   localparam int CW = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          sig_i;
   logic          en_i;
   logic [CW-1:0] freq_o;
   logic          valid_o;
   logic          ovf_o;
   logic          busy_o;

   freq_meter #(
      .GATE_CYCLES (GC),
      .GATE_W      (GW),
      .CNT_W       (CW)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sig_i   (sig_i),
      .en_i    (en_i),
      .freq_o  (freq_o),
      .valid_o (valid_o),
      .ovf_o   (ovf_o),
      .busy_o  (busy_o)
   );

   always #20 clk_i = ~clk_i;

   typedef struct {
      logic [CW-1:0] freq;
      logic          ovf;
      bit            chk;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   mode   = 0;     // 0 low, 1 clk/4, 2 clk/2, 3 manual
   int   ph     = 0;
   logic sig_man = 1'b0;

   // sig_i changes 7 time units after each rising clk edge
   always @(posedge clk_i) begin
      #7;
      ph++;
      case (mode)
         0:       sig_i = 1'b0;
         1:       sig_i = ph[1];
         2:       sig_i = ph[0];
         default: sig_i = sig_man;
      endcase
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic push(input int f, input int o, input bit c);
      exp_t e;
      e.freq = CW'(f);
      e.ovf  = o[0];
      e.chk  = c;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic wait_valid(input int max_cyc, output int n);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (valid_o !== 1'b1 && n < max_cyc);
      if (valid_o !== 1'b1) check("valid_timeout", 32'(valid_o), 32'd1);
   endtask

   always @(negedge clk_i) begin
      if (valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(valid_o), 32'd0);
         end else begin
            e_mon = exp_q.pop_front();
            if (e_mon.chk) begin
               check("window_freq", 32'(freq_o), 32'(e_mon.freq));
               check("window_ovf", 32'(ovf_o), 32'(e_mon.ovf));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_i = 1'b1;
      en_i  = 1'b0;
      sig_i = 1'b0;
      tick(3);
      check("rst_freq", 32'(freq_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_ovf", 32'(ovf_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      rst_i = 1'b0;
      tick(2);

      // sig_i held low
      push(0, 0, 1);
      push(0, 0, 1);
      en_i = 1'b1;
      wait_valid(300, n);
      check("first_valid_latency", 32'(n), 32'd102);
      check("busy_in_gate", 32'(busy_o), 32'd1);
      wait_valid(300, n);
      check("valid_period", 32'(n), 32'd100);
      en_i = 1'b0;
      tick(1);
      check("busy_after_abort", 32'(busy_o), 32'd0);

      // clk/4 -> 25 edges per window
      mode = 1;
      tick(6);
      push(25, 0, 1);
      push(25, 0, 1);
      en_i = 1'b1;
      wait_valid(300, n);
      check("div4_first_latency", 32'(n), 32'd102);
      wait_valid(300, n);
      check("div4_period", 32'(n), 32'd100);

      // abort at gate cycle 50
      tick(50);
      en_i = 1'b0;
      tick(1);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_valid", 32'(valid_o), 32'd0);
      check("abort_freq", 32'(freq_o), 32'd25);
      tick(10);
      check("abort_freq_hold", 32'(freq_o), 32'd25);
      check("abort_ovf_hold", 32'(ovf_o), 32'd0);
      push(25, 0, 1);
      en_i = 1'b1;
      wait_valid(300, n);
      check("rearm_latency", 32'(n), 32'd102);

      // clk/2 saturates, mixed window unchecked, then clk/4 recovers
      en_i = 1'b0;
      mode = 2;
      tick(6);
      push(31, 1, 1);
      push(0, 0, 0);
      push(25, 0, 1);
      en_i = 1'b1;
      wait_valid(300, n);
      check("div2_latency", 32'(n), 32'd102);
      mode = 1;
      wait_valid(300, n);
      wait_valid(300, n);
      check("recover_period", 32'(n), 32'd100);

      // asynchronous reset mid-window
      tick(30);
      @(posedge clk_i);
      #13;
      rst_i = 1'b1;
      #2;
      check("midrst_freq", 32'(freq_o), 32'd0);
      check("midrst_ovf", 32'(ovf_o), 32'd0);
      check("midrst_valid", 32'(valid_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      push(25, 0, 1);
      wait_valid(300, n);
      check("post_rst_latency", 32'(n), 32'd102);
      en_i = 1'b0;

      // single pulse whose edge lands on the terminal cycle
      mode    = 3;
      sig_man = 1'b0;
      tick(8);
      push(1, 0, 1);
      en_i = 1'b1;
      tick(98);
      sig_man = 1'b1;
      tick(2);
      sig_man = 1'b0;
      wait_valid(300, n);
      check("terminal_edge_latency", 32'(n), 32'd2);
      en_i = 1'b0;
      tick(8);

      // edge during ARM is dropped; edge on first cycle of window 2 is kept
      push(0, 0, 1);
      push(1, 0, 1);
      sig_man = 1'b1;
      tick(2);
      en_i    = 1'b1;
      sig_man = 1'b0;
      tick(99);
      sig_man = 1'b1;
      tick(2);
      sig_man = 1'b0;
      tick(1);
      check("arm_window_valid", 32'(valid_o), 32'd1);
      wait_valid(300, n);
      check("second_window_period", 32'(n), 32'd100);
      en_i = 1'b0;
      tick(5);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
